// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive frame controller.
//
// Sequences one serial frame (start, 8 data bits, optional parity, stop)
// against an oversampling clock. It counts oversample edges inside each bit,
// strobes the start/parity/stop checkers and the deserializer once per bit
// at the check point, and reports each frame with a single data_valid or
// frame_err pulse. Back-to-back frames are accepted without an idle cycle.
//
// Check point CP = prescale/2 + 2, bit end BE = prescale - 1. Every strobe is
// high in the cycle where edge_cnt equals CP. The result pulse is high in the
// cycle where edge_cnt equals BE. prescale and PAR_EN are captured at the
// start of each frame.
//
// Optional feature: define UART_RX_PARITY_EN to build the PARITY state and
// honour PAR_EN / par_err. Without it the frame is always start + 8 data +
// stop, PAR_EN and par_err are ignored and par_chk_en is tied low.

module uart_rx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       PAR_EN,
  input  logic       sampled_bit,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       dat_samp_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic       data_valid,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] pre_q;      // prescale captured for the frame in flight
  logic [5:0] cp_m1;      // edge index one before the check point
  logic [5:0] be;         // last edge index of a bit
  logic [5:0] be_m1;      // edge index one before the bit end
  logic       pre_cp;     // next cycle is the check point
  logic       pre_be;     // next cycle is the bit end
  logic       at_be;      // this cycle is the bit end
  logic       frame_ok;   // no stop or parity error for the current frame
  logic       cfg_load;   // a new frame starts at the next clock edge

`ifdef UART_RX_PARITY_EN
  logic par_en_q;         // PAR_EN captured for the frame in flight
  logic par_flag;         // parity error seen in this frame
`endif

  // The strobes are registered, so they are decided one edge early: when the
  // counter is about to reach CP (or BE), the pulse is set for the next cycle.
  assign cp_m1  = {1'b0, pre_q[5:1]} + 6'd1;
  assign be     = pre_q - 6'd1;
  assign be_m1  = pre_q - 6'd2;
  assign pre_cp = (edge_cnt == cp_m1);
  assign pre_be = (edge_cnt == be_m1);
  assign at_be  = (edge_cnt == be);

  // A frame starts from IDLE on a low line, or straight out of STOP when the
  // next start bit is already on the line.
  assign cfg_load = !RX_IN && ((state == IDLE) || ((state == STOP) && at_be));

`ifdef UART_RX_PARITY_EN
  assign frame_ok = !stp_err && !par_flag;
`else
  assign frame_ok = !stp_err;
  assign par_chk_en = 1'b0;
`endif

  // The controller only sequences the sampler; the voted bit itself (and,
  // without the parity build, the parity inputs) is consumed elsewhere.
  logic unused_inputs;
`ifdef UART_RX_PARITY_EN
  assign unused_inputs = sampled_bit;
`else
  assign unused_inputs = ^{sampled_bit, PAR_EN, par_err};
`endif

  // Latch the frame configuration at each frame start so mid-frame changes
  // on prescale / PAR_EN only take effect on the next frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre_q    <= 6'd0;
`ifdef UART_RX_PARITY_EN
      par_en_q <= 1'b0;
`endif
    end else if (cfg_load) begin
      pre_q    <= prescale;
`ifdef UART_RX_PARITY_EN
      par_en_q <= PAR_EN;
`endif
    end
  end

  // Frame sequencer: state, edge/bit counters, strobes and result pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      dat_samp_en <= 1'b0;
      edge_cnt    <= 6'd0;
      bit_cnt     <= 4'd0;
      strt_chk_en <= 1'b0;
      stp_chk_en  <= 1'b0;
      deser_en    <= 1'b0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk_en  <= 1'b0;
      par_flag    <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low every cycle and are only raised for the one
      // cycle they apply to; non-blocking assignment lets a later branch
      // override the default without any ordering hazard.
      strt_chk_en <= 1'b0;
      stp_chk_en  <= 1'b0;
      deser_en    <= 1'b0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk_en  <= 1'b0;
`endif

      case (state)
        IDLE: begin
          edge_cnt <= 6'd0;
          bit_cnt  <= 4'd0;
          if (!RX_IN) begin
            state       <= START;
            dat_samp_en <= 1'b1;
          end
        end

        START: begin
          if (at_be) begin
            edge_cnt <= 6'd0;
            if (strt_glitch) begin
              // Glitch on the start bit: drop the frame without a result.
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= 4'd0;
            end
          end else begin
            edge_cnt    <= edge_cnt + 6'd1;
            strt_chk_en <= pre_cp;
          end
        end

        DATA: begin
          if (at_be) begin
            edge_cnt <= 6'd0;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
              state   <= par_en_q ? PARITY : STOP;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
            deser_en <= pre_cp;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_be) begin
            edge_cnt <= 6'd0;
            par_flag <= par_err;
            state    <= STOP;
          end else begin
            edge_cnt   <= edge_cnt + 6'd1;
            par_chk_en <= pre_cp;
          end
        end
`endif

        STOP: begin
          if (at_be) begin
            edge_cnt <= 6'd0;
`ifdef UART_RX_PARITY_EN
            par_flag <= 1'b0;
`endif
            if (!RX_IN) begin
              state <= START;
            end else begin
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end
          end else begin
            edge_cnt   <= edge_cnt + 6'd1;
            stp_chk_en <= pre_cp;
            if (pre_be) begin
              data_valid <= frame_ok;
              frame_err  <= !frame_ok;
            end
          end
        end

        default: begin
          state       <= IDLE;
          dat_samp_en <= 1'b0;
          edge_cnt    <= 6'd0;
          bit_cnt     <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- self-checking bench for uart_rx_ctrl.
// The bench plays the serial line and the checker results. Each frame
// pushes its expected result pulse onto a queue when it is driven; a monitor
// pops and compares whenever the DUT raises data_valid or frame_err, and
// tallies strobes so each scenario can check counts and edge positions.

module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       deser_en;
  logic       data_valid;
  logic       frame_err;

  uart_rx_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .prescale    (prescale),
    .PAR_EN      (PAR_EN),
    .sampled_bit (sampled_bit),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       valid;
    logic       ferr;
    logic [5:0] edge_v;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [5:0] cur_cp = 6'd6;
  int         strt_cnt, par_cnt, stp_cnt, deser_cnt;
  int         dv_cnt, fe_cnt, bad_edge, bad_bit, idle_cnt;

  // Monitor: sample 1 ns after each rising edge, away from input changes.
  always begin
    @(posedge CLK);
    #1;
    if (RST) begin
      if (!dat_samp_en) idle_cnt++;
      if (strt_chk_en) begin strt_cnt++; if (edge_cnt !== cur_cp) bad_edge++; end
      if (par_chk_en)  begin par_cnt++;  if (edge_cnt !== cur_cp) bad_edge++; end
      if (stp_chk_en)  begin stp_cnt++;  if (edge_cnt !== cur_cp) bad_edge++; end
      if (deser_en) begin
        if (edge_cnt !== cur_cp) bad_edge++;
        if (bit_cnt !== 4'(deser_cnt % 8)) bad_bit++;
        deser_cnt++;
      end
      if (data_valid) dv_cnt++;
      if (frame_err) fe_cnt++;
      if (data_valid || frame_err) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL result_unexpected: dv=%0b fe=%0b edge_cnt=%0d, no result expected",
                   data_valid, frame_err, edge_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          if (data_valid !== mon_e.valid || frame_err !== mon_e.ferr || edge_cnt !== mon_e.edge_v) begin
            tests_failed++;
            $display("FAIL result_pulse: got dv=%0b fe=%0b edge_cnt=%0d, want dv=%0b fe=%0b edge_cnt=%0d",
                     data_valid, frame_err, edge_cnt, mon_e.valid, mon_e.ferr, mon_e.edge_v);
          end
        end
      end
    end
  end

  task automatic clear_counts();
    strt_cnt = 0; par_cnt = 0; stp_cnt = 0; deser_cnt = 0;
    dv_cnt = 0; fe_cnt = 0; bad_edge = 0; bad_bit = 0;
  endtask

  // Drive one frame starting at a falling edge; returns at the falling edge
  // just before the STOP bit-end decision, so a following call is back-to-back.
  task automatic send_frame(input int p, input logic [7:0] data, input logic pe,
                            input logic perr, input logic serr, input logic [5:0] mid_pre);
    int   nb;
    logic par_active;
    logic lvl;
    exp_t e;
`ifdef UART_RX_PARITY_EN
    par_active = pe;
`else
    par_active = 1'b0;
`endif
    nb = par_active ? 11 : 10;
    e.valid  = !(serr || (par_active && perr));
    e.ferr   = !e.valid;
    e.edge_v = 6'(p - 1);
    exp_q.push_back(e);
    prescale = 6'(p); PAR_EN = pe; par_err = perr; stp_err = serr; strt_glitch = 1'b0;
    cur_cp = 6'(p / 2 + 2);
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                         lvl = 1'b0;
      else if (b <= 8)                    lvl = data[b-1];
      else if (par_active && (b == 9))    lvl = ^data;
      else                                lvl = 1'b1;
      RX_IN = lvl; sampled_bit = lvl;
      if ((b == 4) && (mid_pre != 6'd0)) prescale = mid_pre;
      repeat (p) @(negedge CLK);
    end
    RX_IN = 1'b1; sampled_bit = 1'b1;
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    #1;
    tests_run++;
    if ({dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
         data_valid, frame_err} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got samp=%0b edge=%0d bit=%0d strobes=%b dv=%0b fe=%0b, want all 0",
               dat_samp_en, edge_cnt, bit_cnt, {strt_chk_en, par_chk_en, stp_chk_en, deser_en},
               data_valid, frame_err);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    tests_run++;
    if ({dat_samp_en, edge_cnt, bit_cnt} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got samp=%0b edge=%0d bit=%0d, want 0/0/0", dat_samp_en, edge_cnt, bit_cnt);
    end
  endtask

  task automatic test_p8_frame();
    clear_counts();
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 6'd0);
    repeat (4) @(negedge CLK);
    tests_run++;
    if (deser_cnt !== 8 || bad_edge !== 0 || bad_bit !== 0) begin
      tests_failed++;
      $display("FAIL p8_deser: got pulses=%0d bad_edge=%0d bad_bit=%0d, want 8/0/0", deser_cnt, bad_edge, bad_bit);
    end
    tests_run++;
    if (strt_cnt !== 1 || stp_cnt !== 1 || par_cnt !== 0) begin
      tests_failed++;
      $display("FAIL p8_checkers: got strt=%0d stp=%0d par=%0d, want 1/1/0", strt_cnt, stp_cnt, par_cnt);
    end
    tests_run++;
    if (dv_cnt !== 1 || fe_cnt !== 0 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL p8_result: got dv=%0d fe=%0d pending=%0d, want 1/0/0", dv_cnt, fe_cnt, exp_q.size());
    end
    tests_run++;
    if (dat_samp_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL p8_idle: got dat_samp_en=%0b, want 0", dat_samp_en);
    end
  endtask

  task automatic test_parity();
    clear_counts();
    send_frame(16, 8'h96, 1'b1, 1'b1, 1'b0, 6'd0);
    repeat (4) @(negedge CLK);
`ifdef UART_RX_PARITY_EN
    tests_run++;
    if (par_cnt !== 1 || fe_cnt !== 1 || dv_cnt !== 0) begin
      tests_failed++;
      $display("FAIL parity_err: got par=%0d fe=%0d dv=%0d, want 1/1/0", par_cnt, fe_cnt, dv_cnt);
    end
    clear_counts();
    send_frame(16, 8'h3B, 1'b1, 1'b0, 1'b0, 6'd0);
    repeat (4) @(negedge CLK);
    tests_run++;
    if (par_cnt !== 1 || fe_cnt !== 0 || dv_cnt !== 1) begin
      tests_failed++;
      $display("FAIL parity_ok: got par=%0d fe=%0d dv=%0d, want 1/0/1", par_cnt, fe_cnt, dv_cnt);
    end
`else
    tests_run++;
    if (par_cnt !== 0 || fe_cnt !== 0 || dv_cnt !== 1) begin
      tests_failed++;
      $display("FAIL parity_ignored: got par=%0d fe=%0d dv=%0d, want 0/0/1", par_cnt, fe_cnt, dv_cnt);
    end
`endif
    tests_run++;
    if (deser_cnt === 0 || bad_edge !== 0 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL parity_strobes: got deser=%0d bad_edge=%0d pending=%0d, want >0/0/0",
               deser_cnt, bad_edge, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    int s0;
    clear_counts();
    prescale = 6'd8; PAR_EN = 1'b0; stp_err = 1'b0; par_err = 1'b0; strt_glitch = 1'b1;
    cur_cp = 6'd6;
    s0 = idle_cnt;
    RX_IN = 1'b0; sampled_bit = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    repeat (8) @(negedge CLK);
    tests_run++;
    if (idle_cnt - s0 !== 3 || dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
      tests_failed++;
      $display("FAIL glitch_return: got idle_cycles=%0d samp=%0b edge=%0d, want 3/0/0",
               idle_cnt - s0, dat_samp_en, edge_cnt);
    end
    tests_run++;
    if (strt_cnt !== 1 || deser_cnt !== 0 || bad_edge !== 0 || dv_cnt !== 0 || fe_cnt !== 0) begin
      tests_failed++;
      $display("FAIL glitch_pulses: got strt=%0d deser=%0d bad_edge=%0d dv=%0d fe=%0d, want 1/0/0/0/0",
               strt_cnt, deser_cnt, bad_edge, dv_cnt, fe_cnt);
    end
    strt_glitch = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int s0;
    clear_counts();
    s0 = idle_cnt;
    send_frame(32, 8'h3C, 1'b0, 1'b0, 1'b1, 6'd0);
    send_frame(32, 8'hC3, 1'b0, 1'b0, 1'b0, 6'd0);
    tests_run++;
    if (idle_cnt - s0 !== 0) begin
      tests_failed++;
      $display("FAIL b2b_no_idle: got idle_cycles=%0d, want 0", idle_cnt - s0);
    end
    repeat (4) @(negedge CLK);
    tests_run++;
    if (deser_cnt !== 16 || bad_edge !== 0 || bad_bit !== 0 || strt_cnt !== 2 || stp_cnt !== 2) begin
      tests_failed++;
      $display("FAIL b2b_strobes: got deser=%0d bad_edge=%0d bad_bit=%0d strt=%0d stp=%0d, want 16/0/0/2/2",
               deser_cnt, bad_edge, bad_bit, strt_cnt, stp_cnt);
    end
    tests_run++;
    if (fe_cnt !== 1 || dv_cnt !== 1 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_results: got fe=%0d dv=%0d pending=%0d, want 1/1/0", fe_cnt, dv_cnt, exp_q.size());
    end
  endtask

  task automatic test_prescale_change();
    clear_counts();
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 6'd16);
    repeat (4) @(negedge CLK);
    tests_run++;
    if (deser_cnt !== 8 || bad_edge !== 0 || dv_cnt !== 1 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL presc_hold: got deser=%0d bad_edge=%0d dv=%0d pending=%0d, want 8/0/1/0",
               deser_cnt, bad_edge, dv_cnt, exp_q.size());
    end
    clear_counts();
    send_frame(16, 8'h81, 1'b0, 1'b0, 1'b0, 6'd0);
    repeat (4) @(negedge CLK);
    tests_run++;
    if (deser_cnt !== 8 || bad_edge !== 0 || dv_cnt !== 1 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL presc_next: got deser=%0d bad_edge=%0d dv=%0d pending=%0d, want 8/0/1/0",
               deser_cnt, bad_edge, dv_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    prescale = 6'd8; PAR_EN = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0; par_err = 1'b0;
    cur_cp = 6'd6;
    RX_IN = 1'b0; sampled_bit = 1'b0;
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    repeat (34) @(negedge CLK);
    tests_run++;
    if (bit_cnt !== 4'd4 || dat_samp_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got bit_cnt=%0d samp=%0b, want 4/1", bit_cnt, dat_samp_en);
    end
    RST = 1'b0;
    #1;
    tests_run++;
    if ({dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
         data_valid, frame_err} !== 17'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got samp=%0b edge=%0d bit=%0d dv=%0b fe=%0b, want all 0",
               dat_samp_en, edge_cnt, bit_cnt, data_valid, frame_err);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (80) @(negedge CLK);
    tests_run++;
    if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0 || dv_cnt !== 0 || fe_cnt !== 0 || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got samp=%0b edge=%0d dv=%0d fe=%0d pending=%0d, want 0/0/0/0/0",
               dat_samp_en, edge_cnt, dv_cnt, fe_cnt, exp_q.size());
    end
  endtask

  initial begin
    idle_cnt = 0;
    clear_counts();
    test_reset();
    test_p8_frame();
    test_parity();
    test_glitch();
    test_back_to_back();
    test_prescale_change();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
